// File: rtl/muldiv_unit_pkg.sv
// Shared opcodes, divider state encoding and width helpers for the RV32M/RV64M execute unit.
package muldiv_unit_pkg;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, FAST} div_state_e;

  // Iteration counter width: must hold the value XLEN.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider with sign fixup and a fast path for special cases.
// Optional MULDIV_ZERO_SKIP_EN sends |op1| < |op2| divides through the fast path.
module muldiv_div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [XLEN-1:0]  op1,
  input  logic [XLEN-1:0]  op2,
  input  logic [TAG_W-1:0] rd,
  output logic             idle,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] done_rd
);

  localparam int CNT_W = cnt_width(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo, rem, dvs;
  logic             neg_q, neg_r, is_rem;
  logic [TAG_W-1:0] tag;

  logic            signed_op, s1, s2, div_zero, ovf, skip, fast;
  logic [XLEN-1:0] mag1, mag2, fast_q, fast_r;
  logic [XLEN:0]   r_shift, trial;
  logic            ge;
  logic            load, iter;

  assign signed_op = ~op_sel[0];
  assign s1        = signed_op & op1[XLEN-1];
  assign s2        = signed_op & op2[XLEN-1];
  assign mag1      = s1 ? -op1 : op1;
  assign mag2      = s2 ? -op2 : op2;
  assign div_zero  = (op2 == '0);
  assign ovf       = signed_op && (op1 == MIN_VAL) && (op2 == '1);
`ifdef MULDIV_ZERO_SKIP_EN
  assign skip      = (mag1 < mag2);
`else
  assign skip      = 1'b0;
`endif
  assign fast      = div_zero | ovf | skip;
  assign fast_q    = div_zero ? '1 : (ovf ? MIN_VAL : '0);
  assign fast_r    = ovf ? '0 : op1;

  assign r_shift = {rem, quo[XLEN-1]};
  assign trial   = r_shift - {1'b0, dvs};
  assign ge      = ~trial[XLEN];

  assign idle = (state == IDLE);
  assign load = start & idle;
  assign iter = (state == CALC) && (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = fast ? FAST : CALC;
      CALC:  if (cnt == '0) state_nxt = FIXUP;
      FIXUP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      FAST:  if (cnt == '0) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Fast path loads 1 so its result appears one cycle later, matching the CALC->FIXUP handoff.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       cnt <= '0;
    else if (flush)     cnt <= '0;
    else if (load)      cnt <= fast ? CNT_W'(1) : CNT_W'(XLEN);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      quo    <= fast ? fast_q : mag1;
      rem    <= fast ? fast_r : '0;
      dvs    <= mag2;
      neg_q  <= ~fast & (s1 ^ s2);
      neg_r  <= ~fast & s1;
      is_rem <= op_sel[1];
      tag    <= rd;
    end else if (iter) begin
      quo <= {quo[XLEN-2:0], ge};
      rem <= ge ? trial[XLEN-1:0] : r_shift[XLEN-1:0];
    end
  end

  assign result  = is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  assign done_rd = tag;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M execute unit: pipelined multiplier, iterative divider, registered response.
// Build option: define MULDIV_ZERO_SKIP_EN to short-cut divides with |op1| < |op2|.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  op1_i,
  input  logic [XLEN-1:0]  op2_i,
  input  logic [TAG_W-1:0] rd_i,
  output logic             resp_valid_o,
  output logic [XLEN-1:0]  resp_result_o,
  output logic [TAG_W-1:0] resp_rd_o,
  output logic             busy_o
);

  logic [MUL_STAGES-1:0] vld_p;
  logic [XLEN-1:0]       res_p [MUL_STAGES];
  logic [TAG_W-1:0]      rd_p  [MUL_STAGES];

  logic                   accept, mul_accept, div_start;
  logic                   a_sgn, b_sgn;
  logic signed [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]        mul_res;

  logic                   div_idle, div_done;
  logic [XLEN-1:0]        div_result;
  logic [TAG_W-1:0]       div_rd;

  // Divides wait for an empty mul pipe so the two result sources never collide.
  assign req_ready_o = div_idle & ~flush_i & (~funct3_i[2] | ~|vld_p);
  assign accept      = req_valid_i & req_ready_o;
  assign mul_accept  = accept & ~funct3_i[2];
  assign div_start   = accept &  funct3_i[2];

  // Extending to 2*XLEN is equivalent to an XLEN+1 extension for the bits kept.
  assign a_sgn   = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU);
  assign b_sgn   = (funct3_i == F3_MULH);
  assign a_ext   = {{XLEN{a_sgn & op1_i[XLEN-1]}}, op1_i};
  assign b_ext   = {{XLEN{b_sgn & op2_i[XLEN-1]}}, op2_i};
  assign prod    = a_ext * b_ext;
  assign mul_res = (funct3_i == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Stage p0 captures the product; later stages only delay it, leaving room for retiming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p <= '0;
    else if (flush_i) vld_p <= '0;
    else begin
      vld_p[0] <= mul_accept;
      for (int k = 1; k < MUL_STAGES; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    res_p[0] <= mul_res;
    rd_p[0]  <= rd_i;
    for (int k = 1; k < MUL_STAGES; k++) begin
      res_p[k] <= res_p[k-1];
      rd_p[k]  <= rd_p[k-1];
    end
  end

  muldiv_div_iter #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush_i),
    .start   (div_start),
    .op_sel  (funct3_i[1:0]),
    .op1     (op1_i),
    .op2     (op2_i),
    .rd      (rd_i),
    .idle    (div_idle),
    .done    (div_done),
    .result  (div_result),
    .done_rd (div_rd)
  );

  // Response register: result and tag hold between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_o  <= 1'b0;
      resp_result_o <= '0;
      resp_rd_o     <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      if (!flush_i) begin
        if (vld_p[MUL_STAGES-1]) begin
          resp_valid_o  <= 1'b1;
          resp_result_o <= res_p[MUL_STAGES-1];
          resp_rd_o     <= rd_p[MUL_STAGES-1];
        end else if (div_done) begin
          resp_valid_o  <= 1'b1;
          resp_result_o <= div_result;
          resp_rd_o     <= div_rd;
        end
      end
    end
  end

  assign busy_o = (|vld_p) | ~div_idle;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised RV32M/RV64M execute unit that replaces the single-cycle combinational multiply/divide stage.
- Multiplies use a pipelined multiplier of MUL_STAGES stages and may issue back-to-back.
- Divides and remainders use an iterative radix-2 divider with fixed latency, plus a fast path for special cases.
- Sits in the EX stage beside the ALU. It uses a valid/ready request side and a pulse-only response side feeding writeback and the ML bypass.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_STAGES, 2, multiplier pipeline depth in cycles (1..4)
TAG_W, 5, destination register tag width (INSTR_REG_SIZE)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush_i  in  1  synchronous kill of all in-flight operations
req_valid_i  in  1  request valid (caller asserts only for F7_MULDIV ops)
req_ready_o  out  1  unit can accept a request this cycle
funct3_i  in  3  operation (F3_MUL..F3_REMU)
op1_i  in  XLEN  rs1 data
op2_i  in  XLEN  rs2 data
rd_i  in  TAG_W  destination tag
resp_valid_o  out  1  one-cycle result pulse
resp_result_o  out  XLEN  result
resp_rd_o  out  TAG_W  destination tag of result
busy_o  out  1  any operation in flight

Behaviour:
- Reset (async, reset_n=0): all valid bits cleared and divider state IDLE. resp_valid_o=0, resp_result_o=0, resp_rd_o=0, busy_o=0. After release req_ready_o=1.
- Accept: req_valid_i && req_ready_o at rising edge N. With no backpressure, writeback always sinks the result.
- Multiply (funct3[2]=0):
  - Result is resp_valid_o at edge N+MUL_STAGES. One mul per cycle is allowed.
  - Operands are extended to XLEN+1 bits (sign or zero per op); the 2*XLEN product is taken.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- req_ready_o rules:
  - Low while the divider is not IDLE.
  - A div request additionally requires the mul pipeline to be empty. Low during that wait; no response collisions are possible.
- Divide (funct3[2]=1), FSM states IDLE, CALC, FIXUP, FAST:
  - IDLE -> CALC on accept. Operands are converted to magnitudes and signs are recorded. The iteration counter loads XLEN.
  - CALC: one quotient bit per cycle (shift, trial subtract, restore). -> FIXUP when the counter reaches 0.
  - FIXUP: negate the quotient if the signs differ; the remainder takes the dividend sign. resp_valid_o is asserted at edge N+XLEN+2. -> IDLE.
  - FAST: entered from IDLE instead of CALC. resp_valid_o at N+2. -> IDLE.
    - Divide by zero: quotient all-ones, remainder = op1.
    - Signed overflow (DIV/REM with op1=MIN, op2=-1): quotient = MIN, remainder = 0.
- resp_rd_o carries the tag of the completing operation. resp_result_o holds its value between pulses.
- busy_o = any mul stage valid or divider not IDLE.
- Flush: flush_i at edge E clears all mul stage valids and forces the divider to IDLE. There is no response at E or later for killed ops. A request presented in the same cycle as flush_i is not accepted. A response registered at edge E-1 is unaffected.
- Reset mid-operation aborts immediately; there is no response afterwards.

Optional Feature:
MULDIV_ZERO_SKIP_EN
- Defined: a divide with |op1| < |op2| (unsigned magnitude compare, op2 != 0) takes the FAST path, producing quotient 0 and remainder = op1 at N+2.
- Undefined: such divides use the full CALC path at N+XLEN+2 with identical results.

Decomposition:
- PARAMS_pkg gains:
  - typedef enum div_state_e {IDLE, CALC, FIXUP, FAST}
  - XLEN-derived constants
  - reuse of the existing F3_MUL..F3_REMU codes and F7_MULDIV
- One sub-module, muldiv_div_iter, holds the divider FSM, counter and sign fixup. The top keeps the mul pipeline, ready logic and response mux.

Test Plan:
1. MUL 7 x 0xFFFFFFFD, accept at N -> resp_valid_o at N+2, result 0xFFFFFFEB, rd echoed. Next cycle MULH 0x80000000 x 0x80000000 -> 0x40000000 at N+3.
2. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at N+34; REM of the same operands -> 0xFFFFFFFF. req_ready_o stays low N+1..N+34.
3. DIVU 0x1234 / 0 -> 0xFFFFFFFF at N+2; REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
4. MUL at N, DIV requested at N+1 -> DIV is not accepted until the mul completes at N+2. Exactly two responses, in order.
5. flush_i at N+10 of a DIV -> no response, busy_o=0 at N+11, req_ready_o=1. reset_n low mid-DIV -> outputs zeroed asynchronously.
6. DIVU 3 / 10: result at N+2 with MULDIV_ZERO_SKIP_EN, at N+34 without; quotient 0 in both cases.
